pcie_rx_tlp_classifier: RTL and testbench

Registered, parameterised TLP header classifier for the PCIe application RX path. It sits between the RX header extractor and the application request and completion handlers. Each accepted header is tagged with a traffic class (posted / non-posted / completion / other) and a supported/unsupported verdict, with optional 64-bit memory and message support. Non-posted unsupported requests are queued in a UR-completion FIFO for the completion generator, and per-class event counters are maintained.

---
 rtl/pcie_app_pkg.sv | 64 ++++++
 rtl/pcie_ur_fifo.sv | 71 +++++++
 rtl/pcie_rx_tlp_classifier.sv | 158 +++++++++++++++
 tb/tb_pcie_rx_tlp_classifier.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_app_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_app_pkg
// Purpose  : Shared types and TLP header decode for the PCIe application RX
//            path: traffic class enum, Fmt/Type constants, the UR-completion
//            FIFO entry layout and the header classification function.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package pcie_app_pkg;

   typedef enum logic [1:0] {
      CLS_POSTED     = 2'd0,
      CLS_NONPOSTED  = 2'd1,
      CLS_COMPLETION = 2'd2,
      CLS_OTHER      = 2'd3
   } tlp_class_e;

   // {Fmt, Type} encodings for the memory requests decoded exactly
   localparam logic [6:0] C_FT_MRD32 = 7'h00;
   localparam logic [6:0] C_FT_MWR32 = 7'h40;
   localparam logic [6:0] C_FT_MRD64 = 7'h20;
   localparam logic [6:0] C_FT_MWR64 = 7'h60;

   typedef struct packed {
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [2:0]  tc;
   } ur_entry_t;

   localparam int C_UR_ENTRY_W = $bits(ur_entry_t);

   typedef struct packed {
      tlp_class_e cls;
      logic       ur;
   } tlp_decode_t;

   // First matching pattern wins. MsgD (1110xxx) is a subset of the Msg
   // pattern (x110xxx) and shares its verdict, so one item covers both.
   function automatic tlp_decode_t tlp_decode(input logic [1:0] fmt,
                                              input logic [4:0] typ,
                                              input logic       mem64,
                                              input logic       msg);
      tlp_decode_t r;
      r.cls = CLS_OTHER;
      r.ur  = 1'b1;
      casez ({fmt, typ})
         C_FT_MRD32:   begin r.cls = CLS_NONPOSTED;  r.ur = 1'b0;   end
         C_FT_MWR32:   begin r.cls = CLS_POSTED;     r.ur = 1'b0;   end
         C_FT_MRD64:   begin r.cls = CLS_NONPOSTED;  r.ur = !mem64; end
         C_FT_MWR64:   begin r.cls = CLS_POSTED;     r.ur = !mem64; end
         7'b0?00001,                                    // MRdLk
         7'b?000010,                                    // IORd/IOWr
         7'b?00010?,                                    // CfgRd/Wr 0/1
         7'b?011011:   begin r.cls = CLS_NONPOSTED;  r.ur = 1'b1;   end
         7'b?110???:   begin r.cls = CLS_POSTED;     r.ur = !msg;   end
         7'b?00101?:   begin r.cls = CLS_COMPLETION; r.ur = 1'b0;   end
         default:      begin r.cls = CLS_OTHER;      r.ur = 1'b1;   end
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_ur_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ur_fifo
// Purpose  : Small first-word-fall-through FIFO with occupancy output. Used
//            for queued UR completions; generic enough for other short
//            request-tracking queues.
// Ports    : clk, rst_n        - clock, async active-low reset
//            push_i/push_data_i- write strobe and data (ignored when full
//                                unless a pop frees space the same cycle)
//            pop_i             - consume head (ignored when empty)
//            valid_o/head_o    - head entry presence and contents
//            level_o           - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module pcie_ur_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 27
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic                       valid_o,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);
   localparam logic [LW-1:0] C_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;

   logic w_do_pop;
   logic w_do_push;

   assign w_do_pop  = pop_i && (level_q != '0);
   assign w_do_push = push_i && ((level_q != C_FULL) || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + AW'(1);
         end
         if (w_do_pop) begin
            rd_ptr_q <= (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign valid_o = (level_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/pcie_rx_tlp_classifier.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rx_tlp_classifier
// Purpose  : Registered TLP header classifier. Tags each accepted header with
//            a class (P/NP/Cpl/other) and a UR verdict, queues NP unsupported
//            requests for UR completion and keeps saturating event counters.
// Ports    : hdr_*   - header input handshake and fields
//            cls_*   - classification result handshake (1-cycle latency)
//            ur_*    - UR FIFO head handshake, fields and occupancy
//            cnt_clr - synchronous clear of all counters (wins over increment)
//            cnt_*   - per-class / UR event counters
// Revision : 1.0 - initial release
// ============================================================================
module pcie_rx_tlp_classifier
   import pcie_app_pkg::*;
#(
   parameter bit SUPPORT_MEM64 = 1'b0,
   parameter bit SUPPORT_MSG   = 1'b0,
   parameter int UR_DEPTH      = 4,
   parameter int CNT_W         = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       hdr_valid,
   output logic                       hdr_ready,
   input  logic [1:0]                 hdr_fmt,
   input  logic [4:0]                 hdr_type,
   input  logic [15:0]                hdr_req_id,
   input  logic [7:0]                 hdr_tag,
   input  logic [2:0]                 hdr_tc,
   output logic                       cls_valid,
   input  logic                       cls_ready,
   output logic [1:0]                 cls_code,
   output logic                       cls_ur,
   output logic                       ur_valid,
   input  logic                       ur_ready,
   output logic [15:0]                ur_req_id,
   output logic [7:0]                 ur_tag,
   output logic [2:0]                 ur_tc,
   output logic [$clog2(UR_DEPTH):0]  ur_level,
   input  logic                       cnt_clr,
   output logic [CNT_W-1:0]           cnt_np,
   output logic [CNT_W-1:0]           cnt_p,
   output logic [CNT_W-1:0]           cnt_cpl,
   output logic [CNT_W-1:0]           cnt_ur
);
   localparam int LW = $clog2(UR_DEPTH) + 1;
   localparam logic [LW-1:0] C_FULL = LW'(UR_DEPTH);

   logic             cls_valid_q, cls_valid_d;
   tlp_class_e       cls_code_q,  cls_code_d;
   logic             cls_ur_q,    cls_ur_d;
   logic [CNT_W-1:0] cnt_np_q,  cnt_np_d;
   logic [CNT_W-1:0] cnt_p_q,   cnt_p_d;
   logic [CNT_W-1:0] cnt_cpl_q, cnt_cpl_d;
   logic [CNT_W-1:0] cnt_ur_q,  cnt_ur_d;

   tlp_decode_t w_dec;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   ur_entry_t   w_entry;
   ur_entry_t   w_head;
   logic [LW-1:0] w_level;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_dec = tlp_decode(hdr_fmt, hdr_type, SUPPORT_MEM64, SUPPORT_MSG);

   // Uses the pre-pop level: a full FIFO accepts nothing even if popped now.
   assign hdr_ready = (!cls_valid_q || cls_ready) && (w_level < C_FULL);
   assign w_accept  = hdr_valid && hdr_ready;
   assign w_push    = w_accept && (w_dec.cls == CLS_NONPOSTED) && w_dec.ur;
   assign w_pop     = ur_valid && ur_ready;
   assign w_entry   = '{req_id: hdr_req_id, tag: hdr_tag, tc: hdr_tc};

   always_comb begin
      cls_valid_d = cls_valid_q;
      cls_code_d  = cls_code_q;
      cls_ur_d    = cls_ur_q;
      if (w_accept) begin
         cls_valid_d = 1'b1;
         cls_code_d  = w_dec.cls;
         cls_ur_d    = w_dec.ur;
      end else if (cls_ready) begin
         cls_valid_d = 1'b0;
      end

      cnt_np_d  = cnt_np_q;
      cnt_p_d   = cnt_p_q;
      cnt_cpl_d = cnt_cpl_q;
      cnt_ur_d  = cnt_ur_q;
      if (cnt_clr) begin
         cnt_np_d  = '0;
         cnt_p_d   = '0;
         cnt_cpl_d = '0;
         cnt_ur_d  = '0;
      end else if (w_accept) begin
         case (w_dec.cls)
            CLS_NONPOSTED:  cnt_np_d  = sat_inc(cnt_np_q);
            CLS_POSTED:     cnt_p_d   = sat_inc(cnt_p_q);
            CLS_COMPLETION: cnt_cpl_d = sat_inc(cnt_cpl_q);
            default:        ;
         endcase
         if (w_dec.ur) cnt_ur_d = sat_inc(cnt_ur_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_valid_q <= 1'b0;
         cls_code_q  <= CLS_POSTED;
         cls_ur_q    <= 1'b0;
         cnt_np_q    <= '0;
         cnt_p_q     <= '0;
         cnt_cpl_q   <= '0;
         cnt_ur_q    <= '0;
      end else begin
         cls_valid_q <= cls_valid_d;
         cls_code_q  <= cls_code_d;
         cls_ur_q    <= cls_ur_d;
         cnt_np_q    <= cnt_np_d;
         cnt_p_q     <= cnt_p_d;
         cnt_cpl_q   <= cnt_cpl_d;
         cnt_ur_q    <= cnt_ur_d;
      end
   end

   pcie_ur_fifo #(
      .DEPTH (UR_DEPTH),
      .WIDTH (C_UR_ENTRY_W)
   ) u_ur_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (w_push),
      .push_data_i (w_entry),
      .pop_i       (w_pop),
      .valid_o     (ur_valid),
      .head_o      (w_head),
      .level_o     (w_level)
   );

   assign cls_valid = cls_valid_q;
   assign cls_code  = cls_code_q;
   assign cls_ur    = cls_ur_q;
   assign ur_req_id = w_head.req_id;
   assign ur_tag    = w_head.tag;
   assign ur_tc     = w_head.tc;
   assign ur_level  = w_level;
   assign cnt_np    = cnt_np_q;
   assign cnt_p     = cnt_p_q;
   assign cnt_cpl   = cnt_cpl_q;
   assign cnt_ur    = cnt_ur_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_rx_tlp_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_rx_tlp_classifier
// Purpose  : Drives two classifier instances (default parameters, and
//            MEM64+MSG with 4-bit counters) with shared directed and random
//            stimulus, comparing every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_rx_tlp_classifier;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        hdr_valid = 1'b0;
   logic [1:0]  hdr_fmt = '0;
   logic [4:0]  hdr_type = '0;
   logic [15:0] hdr_req_id = '0;
   logic [7:0]  hdr_tag = '0;
   logic [2:0]  hdr_tc = '0;
   logic        cls_ready = 1'b1;
   logic        ur_ready = 1'b0;
   logic        cnt_clr = 1'b0;

   logic [1:0]        o_hdr_ready, o_cls_valid, o_cls_ur, o_ur_valid;
   logic [1:0][1:0]   o_code;
   logic [1:0][15:0]  o_req;
   logic [1:0][7:0]   o_tag;
   logic [1:0][2:0]   o_tc;
   logic [1:0][2:0]   o_lvl;
   logic [1:0][15:0]  o_cnt_np, o_cnt_p, o_cnt_cpl, o_cnt_ur;
   logic [3:0]        b_np, b_p, b_cpl, b_ur;

   assign o_cnt_np[1]  = {12'h0, b_np};
   assign o_cnt_p[1]   = {12'h0, b_p};
   assign o_cnt_cpl[1] = {12'h0, b_cpl};
   assign o_cnt_ur[1]  = {12'h0, b_ur};

   pcie_rx_tlp_classifier u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .hdr_valid(hdr_valid), .hdr_ready(o_hdr_ready[0]),
      .hdr_fmt(hdr_fmt), .hdr_type(hdr_type),
      .hdr_req_id(hdr_req_id), .hdr_tag(hdr_tag), .hdr_tc(hdr_tc),
      .cls_valid(o_cls_valid[0]), .cls_ready(cls_ready),
      .cls_code(o_code[0]), .cls_ur(o_cls_ur[0]),
      .ur_valid(o_ur_valid[0]), .ur_ready(ur_ready),
      .ur_req_id(o_req[0]), .ur_tag(o_tag[0]), .ur_tc(o_tc[0]),
      .ur_level(o_lvl[0]), .cnt_clr(cnt_clr),
      .cnt_np(o_cnt_np[0]), .cnt_p(o_cnt_p[0]),
      .cnt_cpl(o_cnt_cpl[0]), .cnt_ur(o_cnt_ur[0])
   );

   pcie_rx_tlp_classifier #(
      .SUPPORT_MEM64(1'b1), .SUPPORT_MSG(1'b1), .UR_DEPTH(4), .CNT_W(4)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .hdr_valid(hdr_valid), .hdr_ready(o_hdr_ready[1]),
      .hdr_fmt(hdr_fmt), .hdr_type(hdr_type),
      .hdr_req_id(hdr_req_id), .hdr_tag(hdr_tag), .hdr_tc(hdr_tc),
      .cls_valid(o_cls_valid[1]), .cls_ready(cls_ready),
      .cls_code(o_code[1]), .cls_ur(o_cls_ur[1]),
      .ur_valid(o_ur_valid[1]), .ur_ready(ur_ready),
      .ur_req_id(o_req[1]), .ur_tag(o_tag[1]), .ur_tc(o_tc[1]),
      .ur_level(o_lvl[1]), .cnt_clr(cnt_clr),
      .cnt_np(b_np), .cnt_p(b_p), .cnt_cpl(b_cpl), .cnt_ur(b_ur)
   );

   // ---------------- behavioural model ----------------
   int vectors = 0;
   int miscompares = 0;
   int n_acc0 = 0;

   int m_cls_v [2];
   int m_code  [2];
   int m_ur    [2];
   int m_np    [2];
   int m_p     [2];
   int m_cpl   [2];
   int m_urc   [2];
   logic [26:0] q0 [$];
   logic [26:0] q1 [$];

   logic [6:0] picks [10] = '{7'h00, 7'h40, 7'h20, 7'h60, 7'h01,
                              7'h04, 7'h0A, 7'h70, 7'h30, 7'h02};

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %0h want %0h", nm, k, $time, act, exp);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [26:0] qhead(input int k);
      return (k == 0) ? q0[0] : q1[0];
   endfunction

   function automatic int cmax(input int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   function automatic int sat(input int v, input int k);
      return (v >= cmax(k)) ? v : v + 1;
   endfunction

   // Classification from field rules; instance 1 supports MEM64 and MSG.
   function automatic void mdec(input logic [6:0] ft, input int k,
                                output int cls, output int ur);
      logic [1:0] f;
      logic [4:0] t;
      bit ext;
      f = ft[6:5];
      t = ft[4:0];
      ext = (k == 1);
      if (ft == 7'h00)                          begin cls = 1; ur = 0; end
      else if (ft == 7'h40)                     begin cls = 0; ur = 0; end
      else if (ft == 7'h20)                     begin cls = 1; ur = ext ? 0 : 1; end
      else if (ft == 7'h60)                     begin cls = 0; ur = ext ? 0 : 1; end
      else if (f[1] == 0 && t == 5'b00001)      begin cls = 1; ur = 1; end
      else if (f[0] == 0 && t == 5'b00010)      begin cls = 1; ur = 1; end
      else if (f[0] == 0 && t[4:1] == 4'b0010)  begin cls = 1; ur = 1; end
      else if (f[0] == 0 && t == 5'b11011)      begin cls = 1; ur = 1; end
      else if (f[0] == 1 && t[4:3] == 2'b10)    begin cls = 0; ur = ext ? 0 : 1; end
      else if (f[0] == 0 && t[4:1] == 4'b0101)  begin cls = 2; ur = 0; end
      else                                      begin cls = 3; ur = 1; end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cls_v[k] = 0; m_code[k] = 0; m_ur[k] = 0;
         m_np[k] = 0; m_p[k] = 0; m_cpl[k] = 0; m_urc[k] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic check_all(input int k);
      chk("cls_valid", k, 32'(o_cls_valid[k]), m_cls_v[k]);
      chk("cls_code",  k, 32'(o_code[k]),      m_code[k]);
      chk("cls_ur",    k, 32'(o_cls_ur[k]),    m_ur[k]);
      chk("ur_valid",  k, 32'(o_ur_valid[k]),  32'(qsize(k) > 0));
      chk("ur_level",  k, 32'(o_lvl[k]),       qsize(k));
      if (qsize(k) > 0)
         chk("ur_head", k, 32'({o_req[k], o_tag[k], o_tc[k]}), 32'(qhead(k)));
      chk("cnt_np",  k, 32'(o_cnt_np[k]),  m_np[k]);
      chk("cnt_p",   k, 32'(o_cnt_p[k]),   m_p[k]);
      chk("cnt_cpl", k, 32'(o_cnt_cpl[k]), m_cpl[k]);
      chk("cnt_ur",  k, 32'(o_cnt_ur[k]),  m_urc[k]);
   endtask

   // One clock cycle: drive, check ready, advance model, check outputs.
   task automatic step(input bit hv, input logic [6:0] ft, input bit cr,
                       input bit urr, input bit clr);
      int cls, ur;
      bit rdy, acc;
      hdr_valid = hv;
      {hdr_fmt, hdr_type} = ft;
      hdr_req_id = 16'($urandom);
      hdr_tag    = 8'($urandom);
      hdr_tc     = 3'($urandom);
      cls_ready  = cr;
      ur_ready   = urr;
      cnt_clr    = clr;
      #1;
      for (int k = 0; k < 2; k++) begin
         rdy = (m_cls_v[k] == 0 || cr) && (qsize(k) < 4);
         chk("hdr_ready", k, 32'(o_hdr_ready[k]), 32'(rdy));
         acc = hv && rdy;
         if (k == 0 && acc) n_acc0++;
         if (urr && qsize(k) > 0) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
         cls = 0; ur = 0;
         if (acc) begin
            mdec(ft, k, cls, ur);
            m_cls_v[k] = 1; m_code[k] = cls; m_ur[k] = ur;
            if (cls == 1 && ur == 1) begin
               if (k == 0) q0.push_back({hdr_req_id, hdr_tag, hdr_tc});
               else        q1.push_back({hdr_req_id, hdr_tag, hdr_tc});
            end
         end else if (cr) begin
            m_cls_v[k] = 0;
         end
         if (clr) begin
            m_np[k] = 0; m_p[k] = 0; m_cpl[k] = 0; m_urc[k] = 0;
         end else if (acc) begin
            if (cls == 0) m_p[k]   = sat(m_p[k], k);
            if (cls == 1) m_np[k]  = sat(m_np[k], k);
            if (cls == 2) m_cpl[k] = sat(m_cpl[k], k);
            if (ur == 1)  m_urc[k] = sat(m_urc[k], k);
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) check_all(k);
   endtask

   logic [15:0] saved_id;
   int acc_base;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check_all(k);
         chk("rst_hdr_ready", k, 32'(o_hdr_ready[k]), 1);
         chk("rst_ur_fields", k, 32'({o_req[k], o_tag[k], o_tc[k]}), 0);
      end

      // MRd 3DW then MRd 4DW
      step(1, 7'h00, 1, 0, 0);
      chk("mrd32_code", 0, 32'(o_code[0]), 1);
      chk("mrd32_ur",   0, 32'(o_cls_ur[0]), 0);
      step(1, 7'h20, 1, 0, 0);
      saved_id = hdr_req_id;
      chk("mrd64_code", 0, 32'(o_code[0]), 1);
      chk("mrd64_ur",   0, 32'(o_cls_ur[0]), 1);
      chk("mrd64_ur_b", 1, 32'(o_cls_ur[1]), 0);
      chk("mrd64_lvl",  0, 32'(o_lvl[0]), 1);
      chk("mrd64_id",   0, 32'(o_req[0]), 32'(saved_id));
      chk("np_cnt2",    0, 32'(o_cnt_np[0]), 2);
      chk("ur_cnt1",    0, 32'(o_cnt_ur[0]), 1);

      // MWr 4DW and MsgD
      step(0, 7'h00, 1, 1, 1);
      step(1, 7'h60, 1, 0, 0);
      step(1, 7'h70, 1, 0, 0);
      chk("msgd_code", 1, 32'(o_code[1]), 0);
      chk("msgd_ur",   1, 32'(o_cls_ur[1]), 0);
      chk("p_cnt2",    1, 32'(o_cnt_p[1]), 2);
      chk("p_lvl0",    1, 32'(o_lvl[1]), 0);
      chk("p_urcnt_a", 0, 32'(o_cnt_ur[0]), 2);

      // FIFO full backpressure
      n_acc0 = 0;
      repeat (6) step(1, 7'h04, 1, 0, 0);
      chk("full_acc", 0, 32'(n_acc0), 4);
      chk("full_lvl", 0, 32'(o_lvl[0]), 4);
      chk("full_rdy", 0, 32'(o_hdr_ready[0]), 0);
      step(1, 7'h04, 1, 1, 0);
      step(1, 7'h04, 1, 0, 0);
      step(1, 7'h04, 1, 0, 0);
      chk("pulse_acc", 0, 32'(n_acc0), 5);
      chk("pulse_lvl", 1, 32'(o_lvl[1]), 4);

      // cls_ready backpressure, then back-to-back
      repeat (5) step(0, 7'h00, 1, 1, 0);
      step(1, 7'h00, 0, 0, 0);
      repeat (3) step(1, 7'h40, 0, 0, 0);
      chk("stall_rdy",  0, 32'(o_hdr_ready[0]), 0);
      chk("stall_code", 0, 32'(o_code[0]), 1);
      acc_base = n_acc0;
      for (int i = 0; i < 4; i++) step(1, (i % 2) ? 7'h40 : 7'h00, 1, 0, 0);
      chk("b2b_acc", 0, 32'(n_acc0 - acc_base), 4);

      // Counter saturation and clear-wins
      step(0, 7'h00, 1, 1, 1);
      repeat (20) step(1, 7'h0A, 1, 0, 0);
      chk("cpl_sat",  1, 32'(o_cnt_cpl[1]), 15);
      chk("cpl_20",   0, 32'(o_cnt_cpl[0]), 20);
      step(1, 7'h0A, 1, 0, 1);
      chk("clr_wins", 1, 32'(o_cnt_cpl[1]), 0);
      chk("clr_wins", 0, 32'(o_cnt_cpl[0]), 0);

      // Asynchronous reset mid-stream with two UR entries queued
      repeat (2) step(1, 7'h04, 1, 0, 0);
      chk("pre_rst_lvl", 0, 32'(o_lvl[0]), 2);
      #2;
      hdr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("arst_cls_valid", k, 32'(o_cls_valid[k]), 0);
         chk("arst_code",      k, 32'(o_code[k]), 0);
         chk("arst_ur",        k, 32'(o_cls_ur[k]), 0);
         chk("arst_ur_valid",  k, 32'(o_ur_valid[k]), 0);
         chk("arst_lvl",       k, 32'(o_lvl[k]), 0);
         chk("arst_fields",    k, 32'({o_req[k], o_tag[k], o_tc[k]}), 0);
         chk("arst_cnt",       k, 32'(o_cnt_np[k] | o_cnt_p[k] | o_cnt_cpl[k] | o_cnt_ur[k]), 0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("post_rst_rdy", k, 32'(o_hdr_ready[k]), 1);
         check_all(k);
      end

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [6:0] ft;
         if ($urandom_range(0, 3) == 0) ft = 7'($urandom);
         else                           ft = picks[$urandom_range(0, 9)];
         step($urandom_range(0, 9) < 7, ft, $urandom_range(0, 9) < 7,
              $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
